// File: rtl/dacxx1s101.sv
// Write-only serial driver for the TI DACxx1S101 family (8/10/12-bit DACs).
// Takes one sample over an active-low four-phase handshake and shifts out a
// single 16-bit frame on sync/din. clk is also the DAC SCLK. din changes on
// the rising edge so it is stable when the DAC samples on the falling edge.
//
// Ports:
//   clk           system clock, routed to the DAC SCLK pin
//   reset         asynchronous active-low reset
//   startWrite    active-low write request (dataIn/pdMode stable while low)
//   dataIn        unsigned sample, MSB first on the wire
//   pdMode        DAC power-down bits PD1:PD0 (00 = normal operation)
//   sync          DAC SYNC, active-low frame enable
//   din           DAC serial data
//   writeComplete active-low acknowledge
module dacxx1s101 #(
    parameter int unsigned DAC_RES          = 8,
    parameter int unsigned TICKS_WAIT_QUIET = 2,
    parameter int unsigned TICKS_WAIT_RESET = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startWrite,
    input  logic [DAC_RES-1:0] dataIn,
    input  logic [1:0]         pdMode,
    output logic               sync,
    output logic               din,
    output logic               writeComplete
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned QUIET_W = 3;
    localparam int unsigned PAD_W   = 12 - DAC_RES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [QUIET_W-1:0]   quiet_cnt, quiet_nxt;
    logic [FRAME_W-1:0]   shreg, shreg_nxt;
    logic                 sync_nxt, din_nxt, wc_nxt;
    logic [FRAME_W-1:0]   frame_c;
    logic                 request_c;
    logic                 start_c;

    // Frame layout: 00, PD1:PD0, sample left-justified into bits 11..0.
    always_comb begin
        frame_c        = FRAME_W'(dataIn) << PAD_W;
        frame_c[13:12] = pdMode;
    end

    // A new request only counts once the previous ack has been released.
    assign request_c = !startWrite && writeComplete;

    // The quiet count is the number of SYNC-high cycles still owed, so a
    // waiting request may launch on the edge that ends the last one.
    assign start_c = request_c &&
                     ((state == IDLE) ||
                      ((state == QUIET) && (quiet_cnt <= QUIET_W'(1))));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        quiet_nxt   = quiet_cnt;
        shreg_nxt   = shreg;
        sync_nxt    = sync;
        din_nxt     = din;
        wc_nxt      = writeComplete;

        // Ack release: only outside a frame, once the requester lets go.
        if (sync && !writeComplete && startWrite) begin
            wc_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                quiet_nxt   = '0;
            end
            SHIFT: begin
                if (bit_cnt == CNT_W'(FRAME_W)) begin
                    state_nxt = QUIET;
                    sync_nxt  = 1'b1;
                    din_nxt   = 1'b0;
                    quiet_nxt = QUIET_W'(TICKS_WAIT_QUIET);
                    if (!startWrite) begin
                        wc_nxt = 1'b0;
                    end
                end else begin
                    din_nxt     = shreg[FRAME_W-1];
                    shreg_nxt   = {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            QUIET: begin
                bit_cnt_nxt = '0;
                if (quiet_cnt <= QUIET_W'(1)) begin
                    quiet_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    quiet_nxt = quiet_cnt - QUIET_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                sync_nxt  = 1'b1;
                din_nxt   = 1'b0;
            end
        endcase

        // Frame launch: load the whole frame and drive its MSB immediately.
        if (start_c) begin
            state_nxt   = SHIFT;
            shreg_nxt   = {frame_c[FRAME_W-2:0], 1'b0};
            din_nxt     = frame_c[FRAME_W-1];
            sync_nxt    = 1'b0;
            bit_cnt_nxt = CNT_W'(1);
            quiet_nxt   = '0;
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= QUIET;
            bit_cnt       <= '0;
            quiet_cnt     <= QUIET_W'(TICKS_WAIT_RESET);
            shreg         <= '0;
            sync          <= 1'b1;
            din           <= 1'b0;
            writeComplete <= 1'b1;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            quiet_cnt     <= quiet_nxt;
            shreg         <= shreg_nxt;
            sync          <= sync_nxt;
            din           <= din_nxt;
            writeComplete <= wc_nxt;
        end
    end

endmodule

// File: tb/tb_dacxx1s101.sv
// Bench for dacxx1s101: three instances (8/10/12-bit) share clk and reset.
// Stimulus pushes expected frames into per-instance queues; a monitor on the
// falling edge reassembles each SYNC-low window and compares it.
module tb_dacxx1s101;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sw;
    logic [11:0] dat [3];
    logic [1:0]  pd [3];
    logic [2:0]  sync_w;
    logic [2:0]  din_w;
    logic [2:0]  wc_w;

    int total = 0;
    int bad   = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned RES = 8 + 2 * g;
        dacxx1s101 #(
            .DAC_RES(RES),
            .TICKS_WAIT_QUIET(2),
            .TICKS_WAIT_RESET(7)
        ) dut (
            .clk(clk),
            .reset(reset),
            .startWrite(sw[g]),
            .dataIn(dat[g][RES-1:0]),
            .pdMode(pd[g]),
            .sync(sync_w[g]),
            .din(din_w[g]),
            .writeComplete(wc_w[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_exp(input int i, output bit have, output logic [15:0] f);
        have = 1'b0;
        f    = '0;
        case (i)
            0: if (q0.size() != 0) begin have = 1'b1; f = q0.pop_front(); end
            1: if (q1.size() != 0) begin have = 1'b1; f = q1.pop_front(); end
            default: if (q2.size() != 0) begin have = 1'b1; f = q2.pop_front(); end
        endcase
    endtask

    // Count edges until sync of instance i goes low (bounded).
    task automatic wait_sync_low(input int i, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sync_w[i] && n < max);
    endtask

    // Count edges until writeComplete of instance i goes low (bounded).
    task automatic wait_wc_low(input int i, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wc_w[i] && n < max);
    endtask

    // Monitor: gather din while sync is low, compare when sync rises.
    int          n_bits [3] = '{0, 0, 0};
    logic [15:0] acc [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                n_bits[i] = 0;
            end else if (!sync_w[i]) begin
                acc[i] = {acc[i][14:0], din_w[i]};
                n_bits[i]++;
            end else if (n_bits[i] != 0) begin
                bit          have;
                logic [15:0] exp;
                pop_exp(i, have, exp);
                if (!have) begin
                    check($sformatf("unexpected_frame[%0d]", i), 1, 0);
                end else begin
                    check($sformatf("frame_len[%0d]", i), n_bits[i], 16);
                    check($sformatf("frame_bits[%0d]", i), int'(acc[i]), int'(exp));
                end
                n_bits[i] = 0;
            end
        end
    end

    initial begin
        int n;
        int lows;
        reset = 1'b0;
        sw    = 3'b111;
        dat[0] = 12'h0A5;  pd[0] = 2'b00;
        dat[1] = 12'h201;  pd[1] = 2'b01;
        dat[2] = 12'hFFF;  pd[2] = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_outputs[%0d]", i),
                  int'({sync_w[i], din_w[i], wc_w[i]}), 3'b101);
        end

        // Requests held low from reset: one frame each after the reset quiet.
        q0.push_back(16'h0A50);
        q1.push_back(16'h1804);
        q2.push_back(16'h3FFF);
        sw    = 3'b000;
        reset = 1'b1;
        wait_sync_low(0, 20, n);
        check("reset_quiet_edges", n, 7);
        wait_wc_low(0, 40, n);
        check("ack_after_frame", n, 16);
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            lows += (sync_w != 3'b111) ? 1 : 0;
        end
        check("no_second_frame", lows, 0);
        check("ack_held_low", int'(wc_w), 0);
        sw = 3'b111;

        // Handshake from IDLE: ack releases on the next edge, then new frame.
        @(posedge clk);
        #1;
        check("ack_release_idle", int'(wc_w[0]), 1);
        dat[0] = 12'h03C; pd[0] = 2'b10;
        q0.push_back(16'h23C0);
        sw[0] = 1'b0;
        wait_sync_low(0, 5, n);
        check("idle_start_edges", n, 1);
        // Input change in flight must not affect the frame.
        dat[0] = 12'h0C3; pd[0] = 2'b01;
        wait_wc_low(0, 40, n);
        check("ack_after_frame2", n, 16);

        // Release at quiet cycle 0, re-request at quiet cycle 1.
        sw[0] = 1'b1;
        @(posedge clk);
        #1;
        check("ack_release_quiet", int'(wc_w[0]), 1);
        check("sync_high_quiet", int'(sync_w[0]), 1);
        q0.push_back(16'h1C30);
        sw[0] = 1'b0;
        wait_sync_low(0, 10, n);
        check("quiet_gap_edges", n + 1, 2);

        // startWrite rises at bit 5: frame completes, ack never falls.
        repeat (5) @(posedge clk);
        #1;
        sw[0] = 1'b1;
        lows = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            lows += wc_w[0] ? 0 : 1;
        end
        check("no_ack_after_abort_req", lows, 0);
        dat[0] = 12'h081; pd[0] = 2'b00;
        q0.push_back(16'h0810);
        sw[0] = 1'b0;
        wait_sync_low(0, 5, n);
        check("accept_after_release", n, 1);
        wait_wc_low(0, 40, n);
        check("ack_after_frame4", n, 16);
        sw[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Reset at bit 9 abandons the frame asynchronously.
        dat[0] = 12'h05E; pd[0] = 2'b00;
        sw[0] = 1'b0;
        wait_sync_low(0, 5, n);
        check("frame5_start", n, 1);
        repeat (9) @(posedge clk);
        #1;
        check("din_before_reset", int'(din_w[0]), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", int'({sync_w[0], din_w[0], wc_w[0]}), 3'b101);
        dat[0] = 12'h03E;
        q0.push_back(16'h03E0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_sync_low(0, 20, n);
        check("reset_quiet_after_abort", n, 7);
        wait_wc_low(0, 40, n);
        check("ack_after_frame6", n, 16);
        sw = 3'b111;
        repeat (5) @(posedge clk);
        #1;

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dacxx1s101.md
Name: dacxx1s101

Overview:
- Write-only serial driver for the TI DACxx1S101 family (DAC081S101/DAC101S101/DAC121S101), 8/10/12-bit single-channel DACs.
- Data moves in the opposite direction to the ADC capture path: the fabric hands over one sample through a four-phase active-low handshake, and the block shifts out one 16-bit frame on SYNC/DIN.
- The DAC's SCLK is the block's clk, routed to the pin. The DAC samples DIN on the falling SCLK edge, so the block changes DIN only on the rising edge.
- The block sits beside the ADC controller under the same 20 MHz fabric clock.

Parameters:
- DAC_RES, 8, DAC data resolution in bits. Legal values are 8, 10 and 12.
- TICKS_WAIT_QUIET, 2, minimum clk cycles SYNC stays high between frames. Legal range is 1..7.
- TICKS_WAIT_RESET, 7, quiet count loaded on reset, before the first frame is allowed.

Ports:
- clk  input  1  system clock, also the DAC SCLK; rising-edge logic.
- reset  input  1  asynchronous, active-low reset.
- startWrite  input  1  active-low write request. dataIn and pdMode must be stable while it is low.
- dataIn  input  DAC_RES  sample to write; unsigned, MSB first on the wire.
- pdMode  input  2  DAC power-down bits PD1:PD0. 00 is normal operation; 01/10/11 are the power-down modes.
- sync  output  1  DAC SYNC, active-low frame enable.
- din  output  1  DAC serial data.
- writeComplete  output  1  active-low acknowledge.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - sync=1, din=0, writeComplete=1.
  - Bit counter cleared; quiet counter = TICKS_WAIT_RESET.
  - A frame cut short by reset is abandoned. The DAC discards a frame in which SYNC rises before the 16th bit; this is intended.
- Frame format, 16 bits, MSB first:
  - bit 15..14: 00.
  - bit 13..12: pdMode.
  - bit 11..(12-DAC_RES): dataIn.
  - Remaining low bits: 0.
- Shift register: 16 bits, loaded in full at frame start.
- States:
  - IDLE: sync=1, din=0, quiet counter == 0.
  - SHIFT: sync=0.
  - QUIET: sync=1, quiet counter > 0.
- IDLE -> SHIFT on edge E0, requiring startWrite==0 and writeComplete==1 in the same cycle:
  - Latch {00, pdMode, dataIn, pad} into the shift register.
  - sync<=0, din<=frame bit 15, bit counter<=1.
- SHIFT, edges E1..E15: din<=frame bit (15-k) at edge Ek; bit counter increments.
- SHIFT -> QUIET at edge E16:
  - sync<=1, din<=0, quiet counter<=TICKS_WAIT_QUIET.
  - writeComplete<=0 only if startWrite==0 in that cycle.
  - sync is low for exactly 16 clk cycles; DIN bit n is stable across its falling edge.
- QUIET: quiet counter decrements each cycle; the block enters IDLE when the counter reaches 0. Minimum frame-to-frame spacing is 16+TICKS_WAIT_QUIET cycles.
- Ack release: writeComplete<=1 on the first edge at which sync==1, writeComplete==0 and startWrite==1. This can happen in QUIET or IDLE.
- Re-arming:
  - No new frame starts while writeComplete==0, so a startWrite held low produces exactly one frame.
  - The next frame needs startWrite high long enough to release the ack, then low again.
- startWrite rising during SHIFT: the frame still completes all 16 bits, and writeComplete stays 1. This is not an abort.
- startWrite low during QUIET with writeComplete==1: the request is held off until the quiet counter reaches 0, then the frame starts at the next edge. Nothing is lost while startWrite stays low.
- dataIn/pdMode changes after E0 have no effect on the frame in flight.
- Counter widths: bit counter 5 bits; quiet counter 3 bits. Neither counter wraps: the bit counter saturates and clears in QUIET, and the quiet counter stops at 0.

Test Plan:
- Reset release, DAC_RES=8, startWrite held low from reset:
  - Required: sync stays 1 for 7 cycles (TICKS_WAIT_RESET).
  - Then exactly one frame; dataIn=0xA5, pdMode=00 gives din = 0,0,0,0,1,0,1,0,0,1,0,1,0,0,0,0.
  - Then writeComplete=0 and no second frame while startWrite stays low.
- Handshake cycle: raise startWrite after ack.
  - Required: writeComplete returns to 1 at the next edge.
  - Lowering startWrite at quiet cycle 1 delays sync fall until the quiet count expires: SYNC-high gap = TICKS_WAIT_QUIET = 2.
- DAC_RES=12, dataIn=0xFFF, pdMode=11 -> din = 0,0,1,1 then twelve 1s.
- DAC_RES=10, dataIn=0x201, pdMode=01 -> din = 0,0,0,1,1,0,0,0,0,0,0,0,0,1,0,0.
- startWrite deasserted at bit 5 -> all 16 bits shifted, writeComplete never falls, and the next request is accepted normally.
- reset asserted at bit 9 -> sync=1 and din=0 immediately, with no clock edge needed. After release the first frame waits 7 cycles and carries a freshly latched dataIn.
